// File: rtl/multicycle_alu_pkg.sv
// Shared opcodes, FSM state type and the single-cycle operation mux for multicycle_alu.
// Operands are handled at up to MAXW bits; callers zero-extend inputs and truncate the result.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_LUI  = 4'b1101;
  localparam logic [3:0] OP_MOVE = 4'b1111;

  localparam int unsigned MAXW = 64;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  function automatic logic [MAXW-1:0] alu_single(input logic [3:0]      op,
                                                 input logic [MAXW-1:0] a,
                                                 input logic [MAXW-1:0] b,
                                                 input logic [MAXW-1:0] shamt,
                                                 input int unsigned     w);
    logic signed [MAXW-1:0] sa;
    logic signed [MAXW-1:0] sb;
    logic [MAXW-1:0]        r;
    int unsigned            lui_sh;
    // Sign-extend the w-bit operands so SRA and SLT work for any width.
    sa     = $signed(a << (MAXW - w)) >>> (MAXW - w);
    sb     = $signed(b << (MAXW - w)) >>> (MAXW - w);
    lui_sh = (w >= 32) ? 16 : w / 2;
    r      = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << shamt;
      OP_SRL:  r = a >> shamt;
      OP_SUB:  r = a - b;
      OP_SLT:  r = {{(MAXW-1){1'b0}}, (sa < sb)};
      OP_SRA:  r = sa >>> shamt;
      OP_NOR:  r = ~(a | b);
      OP_LUI:  r = b << lui_sh;
      OP_MOVE: r = a;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the EX-stage control and multicycle_alu.
// result_hi exists only when MULTICYCLE_ALU_HI_EN is defined.
interface multicycle_alu_if #(parameter int unsigned WIDTH = 32);
  logic             start;
  logic [3:0]       option;
  logic [WIDTH-1:0] oprd1;
  logic [WIDTH-1:0] oprd2;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic             div_by_zero;
`ifdef MULTICYCLE_ALU_HI_EN
  logic [WIDTH-1:0] result_hi;
`endif

  modport master (
    output start, option, oprd1, oprd2,
    input  result, zero, busy, done, div_by_zero
`ifdef MULTICYCLE_ALU_HI_EN
    , input result_hi
`endif
  );

  modport slave (
    input  start, option, oprd1, oprd2,
    output result, zero, busy, done, div_by_zero
`ifdef MULTICYCLE_ALU_HI_EN
    , output result_hi
`endif
  );
endinterface

// File: rtl/multicycle_alu_muldiv_iter.sv
// Iterative engine: shift-add multiply and restoring unsigned divide sharing one
// 2*WIDTH shift register, counter and adder. done/lo/hi reflect the final step.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int unsigned CW = $clog2(WIDTH);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH-1:0]   m_q;
  logic               div_q;
  logic               last;
  logic [WIDTH+1:0]   x, y, sum;

  assign last = (state == S_RUN) && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = last;
    lo   = acc_step[WIDTH-1:0];
    hi   = acc_step[2*WIDTH-1:WIDTH];
  end

  // MUL adds the multiplicand into the upper half; DIV subtracts the divisor
  // from the shifted partial remainder, carrying one guard bit for the borrow.
  always_comb begin
    x        = div_q ? {1'b0, acc[2*WIDTH-1:WIDTH-1]} : {2'b00, acc[2*WIDTH-1:WIDTH]};
    y        = div_q ? ~{2'b00, m_q} : (acc[0] ? {2'b00, m_q} : '0);
    sum      = x + y + (WIDTH+2)'(div_q);
    acc_step = acc;
    if (div_q) begin
      if (sum[WIDTH+1]) acc_step = {acc[2*WIDTH-2:0], 1'b0};
      else              acc_step = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {sum[WIDTH:0], acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
    end else if (start && state == S_IDLE) begin
      cnt   <= '0;
      acc   <= {{WIDTH{1'b0}}, (is_div ? a : b)};
      m_q   <= is_div ? b : a;
      div_q <= is_div;
    end else if (state == S_RUN) begin
      acc <= acc_step;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered EX-stage ALU: single-cycle ops finish in one cycle, MUL/DIV run WIDTH
// iterations. Define MULTICYCLE_ALU_HI_EN to expose result_hi (upper product / remainder).
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  multicycle_alu_if.slave   bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic             accept, is_md, is_div;
  logic             eng_busy, eng_done;
  logic             dz_pend;
  logic [WIDTH-1:0] eng_lo, single_res;
`ifdef MULTICYCLE_ALU_HI_EN
  logic [WIDTH-1:0] eng_hi;
`else
  logic [WIDTH-1:0] unused_hi;
`endif

  always_comb begin
    is_div     = (bus.option == OP_DIV);
    is_md      = (bus.option == OP_MUL) || is_div;
    accept     = bus.start && !eng_busy;
    single_res = WIDTH'(alu_single(bus.option, MAXW'(bus.oprd1), MAXW'(bus.oprd2),
                                   MAXW'(bus.oprd2[SHW-1:0]), WIDTH));
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_md),
    .is_div (is_div),
    .a      (bus.oprd1),
    .b      (bus.oprd2),
    .busy   (eng_busy),
    .done   (eng_done),
    .lo     (eng_lo),
`ifdef MULTICYCLE_ALU_HI_EN
    .hi     (eng_hi)
`else
    .hi     (unused_hi)
`endif
  );

  assign bus.busy = eng_busy;
  assign bus.zero = (bus.result == '0);

  // Engine completion and a single-cycle accept are exclusive: accept needs busy=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.result      <= '0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      dz_pend         <= 1'b0;
`ifdef MULTICYCLE_ALU_HI_EN
      bus.result_hi   <= '0;
`endif
    end else begin
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      if (eng_done) begin
        bus.result      <= eng_lo;
        bus.done        <= 1'b1;
        bus.div_by_zero <= dz_pend;
`ifdef MULTICYCLE_ALU_HI_EN
        bus.result_hi   <= eng_hi;
`endif
      end else if (accept && !is_md) begin
        bus.result    <= single_res;
        bus.done      <= 1'b1;
`ifdef MULTICYCLE_ALU_HI_EN
        bus.result_hi <= '0;
`endif
      end
      if (accept) dz_pend <= is_div && (bus.oprd2 == '0);
    end
  end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Same 4-bit operation encoding; generic WIDTH.
- Replaces combinational multiply/divide with iterative shift-add / restoring-divide engines, with a start/done handshake.
- Sits in the EX stage. The control unit holds the pipeline while busy=1.

Parameters:
- WIDTH, 32, operand/result width in bits (≥8, power of 2).
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- option  input  4  operation code, sampled on accept
- oprd1  input  WIDTH  operand A, sampled on accept
- oprd2  input  WIDTH  operand B, sampled on accept
- result  output  WIDTH  registered result, held until next accept
- zero  output  1  result==0 (derived from registered result)
- busy  output  1  iterative op in progress
- done  output  1  one-cycle pulse: result valid/updated
- div_by_zero  output  1  set with done for DIV with oprd2==0, else 0

Behaviour:
- Interface: one clock clk; reset rst asynchronous, active-high.
- Reset values: result=0, zero=1, busy=0, done=0, div_by_zero=0. FSM goes to IDLE, iteration counter 0.
- Accept: start=1 && busy=0 at a rising edge. start while busy=1 is ignored, with no queueing.
- Opcodes (unsigned unless noted):
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SLL
  - 0101 SRL
  - 0110 SUB
  - 0111 SLT (signed, 1/0)
  - 1000 MUL (low WIDTH bits)
  - 1001 DIV (quotient)
  - 1010 SRA
  - 1100 NOR
  - 1101 LUI (oprd2<<16; for WIDTH<32 result is oprd2<<(WIDTH/2))
  - 1111 MOVE (oprd1)
  - 1011, 1110: result 0.
- All shifts use oprd2[SHW-1:0] as amount. Add/sub wrap modulo 2^WIDTH, no overflow flag.
- Single-cycle ops: result registered at the accepting edge; done=1 for the next cycle (latency 1). busy stays 0, so back-to-back accepts are allowed every cycle.
- MUL/DIV FSM:
  - IDLE → RUN on accept. busy=1 from the next cycle.
  - RUN: one iteration per cycle, counter 0..WIDTH-1.
  - RUN → IDLE when counter==WIDTH-1. result loaded and done=1 in the following cycle; busy=0 in that same cycle.
  - done asserts exactly WIDTH+1 cycles after the accept edge.
  - A new start during the done cycle is accepted.
- MUL: shift-add on a 2·WIDTH accumulator; result = low WIDTH bits.
- DIV: restoring, unsigned.
  - oprd2==0: still runs WIDTH cycles; result = all ones; div_by_zero=1 with done.
- result/zero change only on a done cycle. Between operations they hold.
- rst mid-RUN aborts immediately to reset values. No done is produced for the aborted op.

Optional Feature:
- Macro MULTICYCLE_ALU_HI_EN.
- Defined:
  - Extra output result_hi [WIDTH-1:0], reset 0, updated only with done.
  - MUL: upper WIDTH product bits.
  - DIV: remainder (oprd1 when divisor 0).
  - Single-cycle ops: 0.
- Undefined: port absent; the remainder/upper-product registers may be trimmed. Behaviour of all other ports is identical.

Decomposition:
- Package alu_pkg:
  - 4-bit opcode localparams (OP_AND … OP_MOVE).
  - FSM state enum {S_IDLE, S_RUN}.
  - Function for the single-cycle op mux.
- One sub-module, muldiv_iter: shared 2·WIDTH shift register, counter and add/sub for both MUL and DIV.
  - Ports: start, is_div, a, b, busy, done, lo, hi.
  - The top contains the single-cycle path, output registers and accept logic.

Test Plan:
- Reset mid-stream: assert rst during RUN of MUL → busy=0, done never pulses, result=0, zero=1; next ADD 3+4 → done after 1 cycle, result=7.
- Single-cycle back-to-back (WIDTH=32): ADD 0xFFFFFFFF+1, then SLT 0xFFFFFFFE vs 1, then SRA 0x80000000 by 4, on consecutive cycles → results 0/zero=1, then 1, then 0xF8000000, each with done.
- MUL 0x0001_0000 × 0x0001_0003 → done exactly 33 cycles after accept, result=0x0003_0000; with MULTICYCLE_ALU_HI_EN, result_hi=0x0000_0001.
- DIV 100/7 → result=14 at cycle 33 (result_hi=2 if enabled). Extra start pulses while busy are ignored; busy=1 for cycles 1..32.
- DIV 5/0 → result=0xFFFFFFFF, div_by_zero=1 with done, result_hi=5 if enabled; next op clears div_by_zero.
- Shift amount: SLL 1 by oprd2=0x0000_0025 → uses amount 5, result=0x20. Opcode 1110 → result 0, zero=1.
